// File: rtl/sha_pkg.sv
// Shared constants and types for the SHA-256 block packing datapath.
package sha_pkg;

    localparam int          WORD_W   = 32;
    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam int          LEN_W    = 64;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PAD     = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Message length in bits, as carried in the final two padded words.
    function automatic logic [LEN_W-1:0] bit_len(input int words);
        return LEN_W'(words) * LEN_W'(WORD_W);
    endfunction

endpackage

// File: rtl/sha_pad_gen.sv
// Constant SHA-256 tail pattern for a fixed header length: the pad word,
// zero fill, then the 64-bit big-endian bit length. The first tail word
// sits in the most significant bits of tail.
module sha_pad_gen
    import sha_pkg::*;
#(
    parameter int MSG_WORDS = 20,
    parameter int OUT_WORDS = 32
) (
    output logic [(OUT_WORDS-MSG_WORDS)*WORD_W-1:0] tail
);

    localparam int TAIL_W = (OUT_WORDS - MSG_WORDS) * WORD_W;

    // Built by a function so a tight fit (no zero words) needs no special case.
    function automatic logic [TAIL_W-1:0] build_tail();
        logic [TAIL_W-1:0] t;
        t = '0;
        t[TAIL_W-1 -: WORD_W] = PAD_WORD;
        t[LEN_W-1:0]          = bit_len(MSG_WORDS);
        return t;
    endfunction

    localparam logic [TAIL_W-1:0] TAIL = build_tail();

    assign tail = TAIL;

endmodule

// File: rtl/header_block_packer.sv
// Packs a streamed block header into a padded SHA-256 message and holds it
// for the hash core until it is accepted.
//
// state   | meaning
// --------+----------------------------------------------------------
// COLLECT | accepting header words into slots 0..MSG_WORDS-1
// PAD     | one cycle: write pad word, zero fill and bit length
// HOLD    | out_data complete and frozen, waiting for out_ready
module header_block_packer
    import sha_pkg::*;
#(
    parameter int MSG_WORDS = 20,
    parameter int OUT_WORDS = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    output logic [OUT_WORDS*32-1:0]        out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(MSG_WORDS+1)-1:0] word_cnt
);

    localparam int CNT_W      = $clog2(MSG_WORDS + 1);
    localparam int TAIL_WORDS = OUT_WORDS - MSG_WORDS;

    state_t                         state;
    logic [WORD_W-1:0]              slots [OUT_WORDS];
    logic [TAIL_WORDS*WORD_W-1:0]   tail;
    logic                           take;

    sha_pad_gen #(
        .MSG_WORDS (MSG_WORDS),
        .OUT_WORDS (OUT_WORDS)
    ) u_pad_gen (
        .tail (tail)
    );

    // Handshake flags decode straight from state so reset clears them without a clock.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign take      = in_ready && in_valid && !flush;

    // Sequencer and header word counter; flush only acts while collecting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COLLECT;
            word_cnt <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (flush) begin
                        word_cnt <= '0;
                    end else if (in_valid) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                        if (word_cnt == CNT_W'(MSG_WORDS - 1)) begin
                            state <= PAD;
                        end
                    end
                end
                PAD: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state    <= COLLECT;
                        word_cnt <= '0;
                    end
                end
                default: begin
                    state    <= COLLECT;
                    word_cnt <= '0;
                end
            endcase
        end
    end

    // Word slots: header words land at word_cnt, the tail is rewritten every PAD,
    // and nothing is written in HOLD so out_data stays frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_WORDS; i++) begin
                slots[i] <= '0;
            end
        end else if (take) begin
            for (int i = 0; i < MSG_WORDS; i++) begin
                if (word_cnt == CNT_W'(i)) begin
                    slots[i] <= in_data;
                end
            end
        end else if (state == PAD) begin
            for (int i = 0; i < TAIL_WORDS; i++) begin
                slots[MSG_WORDS + i] <= tail[(TAIL_WORDS-1-i)*WORD_W +: WORD_W];
            end
        end
    end

    // Flatten slots with word 0 in the most significant position.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < OUT_WORDS; i++) begin
            out_data[(OUT_WORDS-1-i)*WORD_W +: WORD_W] = slots[i];
        end
    end

endmodule

// File: tb/tb_header_block_packer.sv
// Directed bench for header_block_packer with a block scoreboard.
module tb_header_block_packer;

    localparam int MSG_WORDS = 20;
    localparam int OUT_WORDS = 32;
    localparam int OUT_W     = OUT_WORDS * 32;

    logic             clk;
    logic             rst;
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       word_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [OUT_W-1:0] exp_q [$];
    int               rise_t [$];
    logic [OUT_W-1:0] held;
    logic             prev_v = 1'b0;

    header_block_packer #(
        .MSG_WORDS (MSG_WORDS),
        .OUT_WORDS (OUT_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Header word generator; seed 0 is the default header of the test plan.
    function automatic logic [31:0] hw(input int seed, input int i);
        if (seed == 0 && i == 0)  return 32'h0100_0000;
        if (seed == 0 && i == 19) return 32'h0000_0000;
        return {8'(seed + 8'h30), 8'(i), 16'hA5C3 ^ 16'(i * 37 + seed * 11)};
    endfunction

    // Independent model of the padded block for the default geometry.
    function automatic logic [OUT_W-1:0] mk_block(input int seed);
        logic [OUT_W-1:0] b;
        b = '0;
        for (int i = 0; i < MSG_WORDS; i++) b[OUT_W-1-32*i -: 32] = hw(seed, i);
        b[383:352] = 32'h8000_0000;
        b[63:0]    = 64'd640;
        return b;
    endfunction

    function automatic logic [639:0] mk_header(input int seed);
        logic [639:0] h;
        for (int i = 0; i < MSG_WORDS; i++) h[639-32*i -: 32] = hw(seed, i);
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        int w;
        w = 0;
        for (int i = OUT_WORDS - 1; i >= 0; i--) begin
            if (got[OUT_W-1-32*i -: 32] !== exp[OUT_W-1-32*i -: 32]) w = i;
        end
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: word %0d got %h expected %h", tag, w,
                   got[OUT_W-1-32*w -: 32], exp[OUT_W-1-32*w -: 32]);
        end
    endtask

    // Scoreboard: pop on each out_valid rise, check data is frozen while valid.
    always @(negedge clk) begin
        if (out_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $error("FAIL sb_empty: got unexpected block expected none");
            end else begin
                chk_wide("sb_block", out_data, exp_q.pop_front());
            end
            rise_t.push_back(cyc);
            held = out_data;
        end else if (out_valid && prev_v) begin
            chk_wide("hold_stable", out_data, held);
        end
        prev_v = out_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic t;
        logic done;
        done     = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            t = in_ready;
            step();
            if (t) done = 1'b1;
        end
        if (!done) chk("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic send_header(input int seed);
        for (int i = 0; i < MSG_WORDS; i++) send_word(hw(seed, i));
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 40 && !out_valid; k++) step();
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic release_block(input string tag);
        out_ready = 1'b1;
        step();
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_cnt_clear"}, 64'(word_cnt), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk_wide("rst_out_data", out_data, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Default header, in_valid held high, then backpressure in HOLD.
        exp_q.push_back(mk_block(0));
        send_header(0);
        chk("lat_in_ready_drop", 64'(in_ready), 64'd0);
        chk("lat_not_yet_valid", 64'(out_valid), 64'd0);
        chk("lat_cnt_full", 64'(word_cnt), 64'd20);
        step();
        chk("lat_valid_rise", 64'(out_valid), 64'd1);
        n_cmp++;
        assert (out_data[1023:384] === mk_header(0)) else begin
            n_mis++;
            $error("FAIL hdr_slice: got %h expected %h", out_data[1023:960], mk_header(0)[639:576]);
        end
        chk("pad_word", 64'(out_data[383:352]), 64'h8000_0000);
        chk("len_field", out_data[63:0], 64'h280);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        release_block("bp");

        // Gap between words 7 and 8.
        exp_q.push_back(mk_block(1));
        for (int i = 0; i < 7; i++) send_word(hw(1, i));
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("gap_cnt_hold", 64'(word_cnt), 64'd7);
        end
        for (int i = 7; i < MSG_WORDS; i++) send_word(hw(1, i));
        in_valid = 1'b0;
        wait_valid("gap_valid");
        release_block("gap");

        // Flush after 5 words; the word presented with flush is dropped.
        for (int i = 0; i < 5; i++) send_word(hw(2, i));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_cnt", 64'(word_cnt), 64'd0);
        exp_q.push_back(mk_block(3));
        send_header(3);
        wait_valid("flush_valid");
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_in_hold_ignored", 64'(out_valid), 64'd1);
        chk("flush_in_hold_cnt", 64'(word_cnt), 64'd20);
        release_block("flush");

        // Async reset mid-collection.
        for (int i = 0; i < 12; i++) send_word(hw(4, i));
        in_valid = 1'b0;
        chk("pre_rst_cnt", 64'(word_cnt), 64'd12);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt", 64'(word_cnt), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Async reset in HOLD drops out_valid without an edge.
        exp_q.push_back(mk_block(5));
        send_header(5);
        wait_valid("hold_rst_valid");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_hold_valid", 64'(out_valid), 64'd0);
        chk_wide("arst_hold_data", out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        step();

        exp_q.push_back(mk_block(6));
        send_header(6);
        wait_valid("post_rst_valid");
        release_block("post_rst");

        // Back-to-back with out_ready tied high.
        base = rise_t.size();
        out_ready = 1'b1;
        exp_q.push_back(mk_block(7));
        exp_q.push_back(mk_block(8));
        send_header(7);
        send_header(8);
        for (int k = 0; k < 10 && rise_t.size() < base + 2; k++) step();
        chk("b2b_pulses", 64'(rise_t.size() - base), 64'd2);
        if (rise_t.size() >= base + 2)
            chk("b2b_spacing", 64'(rise_t[base+1] - rise_t[base]), 64'd22);
        out_ready = 1'b0;
        step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
